sobel_window_sequencer: RTL and testbench

Streaming front-end controller for the Sobel gradient datapath. Accepts a raster-order 8-bit pixel stream under a valid/ready handshake. Holds two line buffers and a 3x3 shift window, and issues one 72-bit window per interior pixel to the gradient datapath. Tracks the returning magnitude strobes and reports frame completion once the 4-cycle datapath pipeline has drained.

---
 rtl/sobel_window_sequencer_if.sv | 11 +
 rtl/sobel_window_sequencer.sv | 92 +++++++++
 tb/tb_sobel_window_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sobel_window_sequencer_if.sv
// sobel_window_sequencer_if: pixel stream in, 3x3 window out and magnitude strobe back
interface sobel_window_sequencer_if;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        pix_ready;
    logic [71:0] win_data;
    logic        win_valid;
    logic        mag_valid;
    modport master (output pix_in, pix_valid, mag_valid, input pix_ready, win_data, win_valid);
    modport slave  (input pix_in, pix_valid, mag_valid, output pix_ready, win_data, win_valid);
endinterface

// File: rtl/sobel_window_sequencer.sv
// sobel_window_sequencer: line-buffered 3x3 window issue and frame drain tracking for the Sobel datapath
// SOBEL_SEQ_STALL_CNT_EN adds the stall_cycles output counting starved FILL/STREAM cycles.
module sobel_window_sequencer #(
    parameter int IMG_WIDTH  = 256,
    parameter int IMG_HEIGHT = 256
) (
    input  logic                         clk,
    input  logic                         rstN,
    input  logic                         start,
    sobel_window_sequencer_if.slave      s,
    output logic                         busy,
    output logic                         frame_done
`ifdef SOBEL_SEQ_STALL_CNT_EN
    ,
    output logic [31:0]                  stall_cycles
`endif
);
    localparam int CW = 10;
    localparam int AW = $clog2(IMG_WIDTH);
    localparam logic [CW-1:0] W1 = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] H1 = CW'(IMG_HEIGHT - 1);
    localparam logic [19:0] NWIN = 20'((IMG_WIDTH - 2) * (IMG_HEIGHT - 2));
    typedef enum logic [2:0] {IDLE, FILL, STREAM, DRAIN, DONE} state_t;
    state_t state, state_n;
    logic [CW-1:0] col, row;
    logic [19:0] mag_count, mag_next;
    logic [7:0] lb0 [IMG_WIDTH];
    logic [7:0] lb1 [IMG_WIDTH];
    logic [2:0][2:0][7:0] w;
    logic [AW-1:0] idx;
    logic xfer, eol, mag_inc, start_frame;
    assign s.win_data = w;
    assign idx = col[AW-1:0];
    always_comb begin
        xfer = s.pix_valid & s.pix_ready;
        eol = col == W1;
        start_frame = state == IDLE && start;
        mag_inc = s.mag_valid && (state == STREAM || state == DRAIN);
        mag_next = mag_count + 20'(mag_inc);
        busy = state != IDLE;
        frame_done = state == DONE;
        state_n = state;
        case (state)
            IDLE:    state_n = start ? FILL : IDLE;
            FILL:    state_n = (xfer && eol && row == CW'(1)) ? STREAM : FILL;
            STREAM:  state_n = (xfer && eol && row == H1) ? DRAIN : STREAM;
            DRAIN:   state_n = mag_next == NWIN ? DONE : DRAIN;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk)
        if (!rstN) state <= IDLE;
        else state <= state_n;
    always_ff @(posedge clk) begin
        if (!rstN) begin
            s.pix_ready <= 1'b0;
            s.win_valid <= 1'b0;
            w <= '0;
            col <= '0;
            row <= '0;
            mag_count <= '0;
        end else begin
            s.pix_ready <= state_n == FILL || state_n == STREAM;
            s.win_valid <= xfer && state == STREAM && col >= CW'(2);
            mag_count <= start_frame ? '0 : mag_next;
            if (start_frame) begin
                col <= '0;
                row <= '0;
            end else if (xfer) begin
                col <= eol ? '0 : col + CW'(1);
                row <= row + CW'(eol);
            end
            // stale columns after a line wrap shift out before any window with c>=2 is emitted
            if (xfer) begin
                w[0] <= {lb0[idx], w[0][2:1]};
                w[1] <= {lb1[idx], w[1][2:1]};
                w[2] <= {s.pix_in, w[2][2:1]};
            end
        end
    end
    always_ff @(posedge clk)
        if (xfer) begin
            lb0[idx] <= lb1[idx];
            lb1[idx] <= s.pix_in;
        end
`ifdef SOBEL_SEQ_STALL_CNT_EN
    always_ff @(posedge clk)
        if (!rstN || start_frame) stall_cycles <= '0;
        else if ((state == FILL || state == STREAM) && !s.pix_valid) stall_cycles <= stall_cycles + 32'd1;
`endif
endmodule

// File: tb/tb_sobel_window_sequencer.sv
// tb_sobel_window_sequencer: directed 5x4 frames with a 4-cycle datapath model returning mag_valid
module tb_sobel_window_sequencer;
    logic clk = 1'b0;
    logic rstN, start, busy, frame_done, spur;
    logic [3:0] dp = '0;
    logic prev_wv = 1'b0;
    int checks = 0, errors = 0, fd_count = 0, adj = 0;
    logic [71:0] wq [$];
`ifdef SOBEL_SEQ_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif
    sobel_window_sequencer_if ifc ();
    sobel_window_sequencer #(.IMG_WIDTH(5), .IMG_HEIGHT(4)) dut (
        .clk(clk), .rstN(rstN), .start(start), .s(ifc.slave), .busy(busy), .frame_done(frame_done)
`ifdef SOBEL_SEQ_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );
    always #5 clk = ~clk;
    always @(posedge clk) dp <= {dp[2:0], ifc.win_valid};
    assign ifc.mag_valid = dp[3] | spur;
    always @(negedge clk) begin
        if (ifc.win_valid) wq.push_back(ifc.win_data);
        if (ifc.win_valid && prev_wv) adj++;
        if (frame_done) fd_count++;
        prev_wv = ifc.win_valid;
    end
    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic [71:0] exp_win(input int base, input int r, input int c);
        logic [71:0] e = '0;
        for (int j = 0; j < 3; j++)
            for (int k = 0; k < 3; k++)
                e[(3*j+k)*8 +: 8] = 8'(base + 5*(r-2+j) + (c-2+k));
        return e;
    endfunction
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask
    task automatic send_pix(input int base, input int n, input bit stall, input bit mid_start, input bit spur_fill);
        for (int i = 0; i < n; i++) begin
            if (stall && i > 0) begin
                ifc.pix_valid = 1'b0;
                @(negedge clk);
            end
            ifc.pix_valid = 1'b1;
            ifc.pix_in = 8'(base + i);
            start = mid_start && i == 15;
            spur = spur_fill && i < 3;
            for (int t = 0; t < 8 && !ifc.pix_ready; t++) @(negedge clk);
            @(negedge clk);
            start = 1'b0;
            spur = 1'b0;
        end
        ifc.pix_valid = 1'b0;
    endtask
    task automatic run_frame(input int base, input bit stall, input bit mid_start, input bit spur_fill);
        int n = 0;
        wq.delete();
        fd_count = 0;
        pulse_start();
        send_pix(base, 20, stall, mid_start, spur_fill);
        while (!frame_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        // frame_done is seen 5 negedges after the edge that took the last pixel: 6 cycles after its transfer cycle
        chk("done_latency", 72'(n), 72'd5);
        start = mid_start;
        @(negedge clk);
        start = 1'b0;
        chk("idle_after_done", 72'(busy), 72'd0);
        chk("frame_done_once", 72'(fd_count), 72'd1);
    endtask
    task automatic check_windows(input int base);
        chk("win_count", 72'(wq.size()), 72'd6);
        for (int i = 0; i < 6 && i < wq.size(); i++)
            chk($sformatf("win_%0d_base_%0d", i, base), wq[i], exp_win(base, 2 + i / 3, 2 + i % 3));
    endtask
    initial begin
        rstN = 1'b0;
        start = 1'b0;
        spur = 1'b0;
        ifc.pix_valid = 1'b0;
        ifc.pix_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_pix_ready", 72'(ifc.pix_ready), 72'd0);
        chk("rst_win_valid", 72'(ifc.win_valid), 72'd0);
        chk("rst_win_data", ifc.win_data, 72'd0);
        chk("rst_busy", 72'(busy), 72'd0);
        chk("rst_frame_done", 72'(frame_done), 72'd0);
        rstN = 1'b1;
        @(negedge clk);
        run_frame(0, 0, 0, 0);
        check_windows(0);
        if (wq.size() > 0) chk("first_window", wq[0], 72'h0C_0B_0A_07_06_05_02_01_00);
        run_frame(200, 0, 0, 0);
        check_windows(200);
        adj = 0;
        run_frame(30, 1, 0, 0);
        check_windows(30);
        chk("no_adjacent_win_valid", 72'(adj), 72'd0);
`ifdef SOBEL_SEQ_STALL_CNT_EN
        chk("stall_cycles", 72'(stall_cycles), 72'd19);
`endif
        run_frame(60, 0, 1, 0);
        check_windows(60);
        wq.delete();
        pulse_start();
        send_pix(0, 10, 0, 0, 0);
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        chk("mid_rst_pix_ready", 72'(ifc.pix_ready), 72'd0);
        chk("mid_rst_win_valid", 72'(ifc.win_valid), 72'd0);
        chk("mid_rst_win_data", ifc.win_data, 72'd0);
        chk("mid_rst_busy", 72'(busy), 72'd0);
        chk("mid_rst_frame_done", 72'(frame_done), 72'd0);
        chk("mid_rst_no_windows", 72'(wq.size()), 72'd0);
        @(negedge clk);
        run_frame(90, 0, 0, 0);
        check_windows(90);
        spur = 1'b1;
        repeat (3) @(negedge clk);
        spur = 1'b0;
        @(negedge clk);
        run_frame(120, 0, 0, 1);
        check_windows(120);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
